score_event_sched: RTL and testbench

//  Sequences the score ALU. Collects single-cycle scoring events from the game

---
 rtl/score_event_sched.sv | 151 +++++++++++++++
 tb/tb_score_event_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/score_event_sched.sv
// Score ALU sequencer: queues per-source scoring events and arbitrates among them.
// It issues one ALU op per cycle and expands a ghost combo into repeated +20 ops.
module score_event_sched #(
    parameter int CNT_W     = 4,
    parameter int MAX_COMBO = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pellet_evt,
    input  logic       power_evt,
    input  logic       ghost_evt,
    input  logic       double_evt,
    input  logic       frightened,
    output logic [1:0] alu_select,
    output logic       alu_enable,
    output logic       busy,
    output logic [2:0] combo,
    output logic       drop_err
);

    // Source index equals the ALU op code of that source.
    localparam int SRC_PELLET = 0;
    localparam int SRC_GHOST  = 1;
    localparam int SRC_POWER  = 2;
    localparam int SRC_DOUBLE = 3;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [2:0]       COMBO_MAX = 3'(MAX_COMBO);

    typedef enum logic {
        IDLE,
        GHOST_SEQ
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt [4];
    logic [2:0]       r_rem;
    logic [2:0]       w_rem_nxt;
    logic [2:0]       r_combo;
    logic [2:0]       w_combo_nxt;
    logic [2:0]       w_rep;
    logic [1:0]       r_sel;
    logic [1:0]       w_sel_nxt;
    logic             r_en;
    logic             w_en_nxt;
    logic             r_drop;
    logic [3:0]       w_evt;
    logic [3:0]       w_nz;
    logic [3:0]       w_grant;

    assign w_evt = {double_evt, power_evt, ghost_evt, pellet_evt};

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_nz[i] = (r_cnt[i] != '0);
        end
    end

    assign w_rep = (r_combo >= COMBO_MAX) ? COMBO_MAX : r_combo + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_combo_nxt = frightened ? r_combo : 3'd0;
        w_sel_nxt   = r_sel;
        w_en_nxt    = 1'b0;
        w_grant     = '0;
        case (r_state)
            IDLE: begin
                // Double is lowest priority so it multiplies adds already queued.
                if (w_nz[SRC_POWER]) begin
                    w_grant[SRC_POWER] = 1'b1;
                    w_en_nxt           = 1'b1;
                    w_sel_nxt          = 2'(SRC_POWER);
                end else if (w_nz[SRC_GHOST]) begin
                    w_grant[SRC_GHOST] = 1'b1;
                    w_en_nxt           = 1'b1;
                    w_sel_nxt          = 2'(SRC_GHOST);
                    w_combo_nxt        = frightened ? w_rep : 3'd0;
                    if (w_rep > 3'd1) begin
                        w_rem_nxt   = w_rep - 3'd1;
                        w_state_nxt = GHOST_SEQ;
                    end
                end else if (w_nz[SRC_PELLET]) begin
                    w_grant[SRC_PELLET] = 1'b1;
                    w_en_nxt            = 1'b1;
                    w_sel_nxt           = 2'(SRC_PELLET);
                end else if (w_nz[SRC_DOUBLE]) begin
                    w_grant[SRC_DOUBLE] = 1'b1;
                    w_en_nxt            = 1'b1;
                    w_sel_nxt           = 2'(SRC_DOUBLE);
                end
            end
            GHOST_SEQ: begin
                w_en_nxt  = 1'b1;
                w_sel_nxt = 2'(SRC_GHOST);
                w_rem_nxt = r_rem - 3'd1;
                if (r_rem == 3'd1) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_rem   <= '0;
            r_combo <= '0;
            r_sel   <= 2'b00;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_combo <= w_combo_nxt;
            r_sel   <= w_sel_nxt;
            r_en    <= w_en_nxt;
        end
    end

    // A pulse arriving with a grant on the same source leaves the count unchanged.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) begin
                r_cnt[i] <= '0;
            end
            r_drop <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (w_evt[i] && !w_grant[i]) begin
                    if (r_cnt[i] != CNT_MAX) begin
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    end else begin
                        r_drop <= 1'b1;
                    end
                end else if (!w_evt[i] && w_grant[i]) begin
                    r_cnt[i] <= r_cnt[i] - 1'b1;
                end
            end
        end
    end

    assign alu_select = r_sel;
    assign alu_enable = r_en;
    assign combo      = r_combo;
    assign drop_err   = r_drop;
    assign busy       = (|w_nz) || (r_state == GHOST_SEQ);

endmodule

// File: tb/tb_score_event_sched.sv
// Bench for score_event_sched: directed scenarios plus random traffic, checked
// every cycle against a queue-count model of the scoring rules.
module tb_score_event_sched;

    localparam int CNT_W     = 4;
    localparam int MAX_COMBO = 4;
    localparam int QMAX      = (1 << CNT_W) - 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pellet_evt = 1'b0;
    logic       power_evt = 1'b0;
    logic       ghost_evt = 1'b0;
    logic       double_evt = 1'b0;
    logic       frightened = 1'b0;
    logic [1:0] alu_select;
    logic       alu_enable;
    logic       busy;
    logic [2:0] combo;
    logic       drop_err;

    score_event_sched #(.CNT_W(CNT_W), .MAX_COMBO(MAX_COMBO)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pellet_evt (pellet_evt),
        .power_evt  (power_evt),
        .ghost_evt  (ghost_evt),
        .double_evt (double_evt),
        .frightened (frightened),
        .alu_select (alu_select),
        .alu_enable (alu_enable),
        .busy       (busy),
        .combo      (combo),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: queued work per source (index = op code), ghost ops still owed.
    int q [4];
    int owed_m  = 0;
    int combo_m = 0;
    int drop_m  = 0;
    int sel_m   = 0;
    int en_m    = 0;

    // Observed activity since the last clear.
    int ops [4];
    int score = 0;
    int sel_hist [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic clear_obs();
        for (int i = 0; i < 4; i++) ops[i] = 0;
        score = 0;
        sel_hist.delete();
    endtask

    task automatic model(input bit rn, input bit [3:0] ev, input bit f);
        int prio [4] = '{2, 1, 0, 3};
        int gr;
        int rep;
        gr = -1;
        if (!rn) begin
            for (int i = 0; i < 4; i++) q[i] = 0;
            owed_m = 0; combo_m = 0; drop_m = 0; sel_m = 0; en_m = 0;
            return;
        end
        if (owed_m > 0) begin
            owed_m--;
            en_m = 1; sel_m = 1;
            combo_m = f ? combo_m : 0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (gr < 0 && q[prio[k]] > 0) gr = prio[k];
            end
            if (gr == 1) begin
                rep = (combo_m + 1 > MAX_COMBO) ? MAX_COMBO : combo_m + 1;
                owed_m  = rep - 1;
                combo_m = f ? rep : 0;
            end else begin
                combo_m = f ? combo_m : 0;
            end
            en_m = (gr >= 0);
            if (gr >= 0) sel_m = gr;
        end
        for (int s = 0; s < 4; s++) begin
            if (ev[s]) begin
                if (q[s] < QMAX || gr == s) q[s]++;
                else drop_m = 1;
            end
            if (gr == s) q[s]--;
        end
    endtask

    // ev bits: {double, power, ghost, pellet}
    task automatic step(input bit rn, input bit [3:0] ev, input bit f);
        int busy_m;
        reset_n    = rn;
        pellet_evt = ev[0];
        ghost_evt  = ev[1];
        power_evt  = ev[2];
        double_evt = ev[3];
        frightened = f;
        @(posedge clk);
        model(rn, ev, f);
        #1;
        busy_m = (owed_m > 0) ? 1 : 0;
        for (int i = 0; i < 4; i++) if (q[i] > 0) busy_m = 1;
        chk("enable", 32'(alu_enable), 32'(en_m));
        chk("select", 32'(alu_select), 32'(sel_m));
        chk("combo", 32'(combo), 32'(combo_m));
        chk("drop_err", 32'(drop_err), 32'(drop_m));
        chk("busy", 32'(busy), 32'(busy_m));
        if (alu_enable === 1'b1) begin
            ops[alu_select]++;
            sel_hist.push_back(int'(alu_select));
            case (alu_select)
                2'b00: score += 10;
                2'b01: score += 20;
                2'b10: score += 50;
                default: score *= 2;
            endcase
        end
        pellet_evt = 1'b0; ghost_evt = 1'b0; power_evt = 1'b0; double_evt = 1'b0;
    endtask

    task automatic idle(input int n, input bit f);
        for (int i = 0; i < n; i++) step(1'b1, 4'b0000, f);
    endtask

    task automatic do_reset();
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) q[i] = 0;

        // T1: single pellet, enable two cycles after the pulse
        do_reset();
        chk("reset_enable", 32'(alu_enable), 32'd0);
        chk("reset_select", 32'(alu_select), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        clear_obs();
        step(1'b1, 4'b0001, 1'b0);
        chk("t1_no_early_enable", 32'(alu_enable), 32'd0);
        step(1'b1, 4'b0000, 1'b0);
        chk("t1_enable", 32'(alu_enable), 32'd1);
        idle(3, 1'b0);
        chk("t1_ops", 32'(ops[0]), 32'd1);
        chk("t1_score", 32'(score), 32'd10);
        chk("t1_busy_after", 32'(busy), 32'd0);

        // T2: all four at once, strict priority order
        clear_obs();
        step(1'b1, 4'b1111, 1'b0);
        idle(6, 1'b0);
        chk("t2_count", 32'(sel_hist.size()), 32'd4);
        if (sel_hist.size() == 4) begin
            chk("t2_seq0", 32'(sel_hist[0]), 32'd2);
            chk("t2_seq1", 32'(sel_hist[1]), 32'd1);
            chk("t2_seq2", 32'(sel_hist[2]), 32'd0);
            chk("t2_seq3", 32'(sel_hist[3]), 32'd3);
        end
        chk("t2_score", 32'(score), 32'd160);

        // T3: escalating ghost combo, capped at MAX_COMBO
        do_reset();
        clear_obs();
        for (int g = 1; g <= 5; g++) begin
            for (int i = 0; i < 4; i++) ops[i] = 0;
            step(1'b1, 4'b0010, 1'b1);
            idle(9, 1'b1);
            chk("t3_burst_ops", 32'(ops[1]), 32'((g > MAX_COMBO) ? MAX_COMBO : g));
            chk("t3_combo", 32'(combo), 32'((g > MAX_COMBO) ? MAX_COMBO : g));
            if (g == 4) chk("t3_score", 32'(score), 32'd200);
        end

        // T4: pellets pile up behind power traffic until they saturate
        do_reset();
        clear_obs();
        for (int i = 0; i < 20; i++) step(1'b1, 4'b0101, 1'b0);
        chk("t4_drop", 32'(drop_err), 32'd1);
        chk("t4_no_pellet_yet", 32'(ops[0]), 32'd0);
        idle(30, 1'b0);
        chk("t4_pellet_ops", 32'(ops[0]), 32'(QMAX));
        chk("t4_drop_sticky", 32'(drop_err), 32'd1);

        // T5: reset in the middle of a combo-3 ghost sequence
        do_reset();
        step(1'b1, 4'b0010, 1'b1);
        idle(7, 1'b1);
        step(1'b1, 4'b0010, 1'b1);
        idle(7, 1'b1);
        step(1'b1, 4'b0010, 1'b1);
        idle(2, 1'b1);
        chk("t5_in_seq", 32'(busy), 32'd1);
        step(1'b0, 4'b0000, 1'b1);
        chk("t5_enable_off", 32'(alu_enable), 32'd0);
        chk("t5_combo_off", 32'(combo), 32'd0);
        chk("t5_busy_off", 32'(busy), 32'd0);
        clear_obs();
        idle(10, 1'b1);
        chk("t5_nothing_issued", 32'(sel_hist.size()), 32'd0);

        // T6: frightened drops between two ghosts
        do_reset();
        step(1'b1, 4'b0010, 1'b1);
        idle(5, 1'b1);
        chk("t6_combo1", 32'(combo), 32'd1);
        idle(1, 1'b0);
        clear_obs();
        step(1'b1, 4'b0010, 1'b0);
        idle(5, 1'b0);
        chk("t6_ops", 32'(ops[1]), 32'd1);
        chk("t6_combo0", 32'(combo), 32'd0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            bit [3:0] ev;
            bit rn;
            bit f;
            for (int s = 0; s < 4; s++) ev[s] = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 60) == 0) ev = 4'b1111;
            rn = ($urandom_range(0, 250) != 0);
            f  = ($urandom_range(0, 9) != 0);
            step(rn, ev, f);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
